pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of cycles Flush is held after a redirect (legal 1..15).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-006 BranchTaken  input  1  EX-stage redirect request, one-cycle pulse.
REQ-007 BranchTarget  input  32  redirect address, valid with BranchTaken.
REQ-008 PCAddResult  input  32  next sequential PC from the PC adder.
REQ-009 IAck  input  1  instruction memory returns InstrIn this cycle.
REQ-010 InstrIn  input  32  instruction word from instruction memory.
REQ-011 PCResult  output  32  current fetch PC; drives the PC adder and the memory address.
REQ-012 IReq  output  1  fetch request to instruction memory for address PCResult.
REQ-013 InstrOut  output  32  captured instruction for IF/ID.
REQ-014 InstrValid  output  1  InstrOut holds a live instruction.
REQ-015 Flush  output  1  squash IF/ID and feed the PC adder flush input.

Function
REQ-016 SHALL implement a three-state FSM: FETCH, HOLD, FLUSH; all outputs registered except IReq, which is decoded from the state.
REQ-017 In FETCH, IReq SHALL be 1; in HOLD and FLUSH, IReq SHALL be 0.
REQ-018 In FETCH with IAck=1 and Stall=0: InstrOut<=InstrIn, InstrValid<=1, PCResult<=PCAddResult, stay in FETCH.
REQ-019 In FETCH with IAck=1 and Stall=1: InstrOut<=InstrIn, InstrValid<=1, PCResult unchanged, go to HOLD.
REQ-020 In FETCH with IAck=0: PCResult unchanged, InstrValid<=0 if Stall=0, otherwise InstrValid is held.
REQ-021 In HOLD, InstrOut, InstrValid and PCResult SHALL be held while Stall=1.
REQ-022 In HOLD with Stall=0: PCResult<=PCAddResult, InstrValid<=0, go to FETCH.
REQ-023 BranchTaken=1 SHALL take priority over Stall and IAck in every state.
REQ-024 On BranchTaken: PCResult<={BranchTarget[31:2],2'b00}, InstrValid<=0, Flush<=1, counter<=FLUSH_CYCLES-1, go to FLUSH; a same-cycle IAck is discarded.
REQ-025 In FLUSH: Flush stays 1 and the 4-bit counter decrements each cycle; when counter=0, Flush<=0 and go to FETCH.
REQ-026 Result of REQ-024/REQ-025: Flush is high for exactly FLUSH_CYCLES cycles per redirect.
REQ-027 BranchTaken during FLUSH SHALL reload the target and restart the counter.
REQ-028 IAck while IReq=0 SHALL be ignored.
REQ-029 PCResult SHALL wrap modulo 2^32; no overflow flag.

Reset
REQ-030 On Reset=1 at a clock edge: PCResult<=RESET_PC, state<=FETCH, InstrOut<=0, InstrValid<=0, Flush<=0, counter<=0.
REQ-031 Reset SHALL override BranchTaken, Stall and IAck, including mid-FLUSH and mid-HOLD.
REQ-032 IReq SHALL be 0 during any cycle in which Reset=1, and 1 in the first cycle after release.

Structure
REQ-033 Shared package holds the FSM state encoding (2 bits: FETCH=0, HOLD=1, FLUSH=2), the RESET_PC default and the instruction width constant.
REQ-034 Flat module; a single sub-module flush_counter (4-bit loadable down-counter with a zero flag) is permitted.

Verification
REQ-035 Reset release with RESET_PC=0 and IAck tied 1, Stall=0 -> PCResult 0,4,8,12 on consecutive cycles; InstrValid=1 from the second cycle.
REQ-036 Stall=1 for 3 cycles at PC=8 with IAck=1 -> state HOLD; PCResult=8 and InstrOut stable for 3 cycles; PC=12 the cycle after Stall drops.
REQ-037 BranchTaken with BranchTarget=32'h0000_0103 and a same-cycle IAck -> PCResult=32'h0000_0100, Flush=1 for 2 cycles, IReq=0 for 2 cycles, InstrValid=0, fetch resumes at 0x100.
REQ-038 Second BranchTaken (target 0x200) in the first FLUSH cycle -> PCResult=0x200, Flush held 2 more cycles, total 3.
REQ-039 Reset asserted mid-FLUSH -> the next cycle shows PCResult=RESET_PC, Flush=0, InstrValid=0, and IReq=1 after release.
REQ-040 PCAddResult driven to 0 from PC=32'hFFFF_FFFC with IAck=1 -> PCResult=0, no error.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared FSM encoding and constants for the fetch controller
package pc_fetch_ctrl_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int INSTR_W = 32;
endpackage

// File: rtl/pc_fetch_ctrl_flush_counter.sv
// pc_fetch_ctrl_flush_counter: 4-bit loadable down-counter with zero flag
module pc_fetch_ctrl_flush_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] value,
  output logic       zero
);
  logic [3:0] count;
  // load wins over decrement so a redirect restarts the flush window
  always_ff @(posedge clk)
    if (rst) count <= 4'd0;
    else if (load) count <= value;
    else if (en) count <= count - 4'd1;
  assign zero = count == 4'd0;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction fetch PC/handshake controller with redirect flush
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [31:0]        BranchTarget,
  input  logic [31:0]        PCAddResult,
  input  logic               IAck,
  input  logic [INSTR_W-1:0] InstrIn,
  output logic [31:0]        PCResult,
  output logic               IReq,
  output logic [INSTR_W-1:0] InstrOut,
  output logic               InstrValid,
  output logic               Flush
);
  state_t state, next_state;
  logic cnt_zero;
  pc_fetch_ctrl_flush_counter flush_counter (
    .clk(Clk),
    .rst(Reset),
    .load(BranchTaken),
    .en(state == FLUSH && !cnt_zero),
    .value(4'(FLUSH_CYCLES - 1)),
    .zero(cnt_zero)
  );
  // state register
  always_ff @(posedge Clk)
    if (Reset) state <= FETCH;
    else state <= next_state;
  // next state: a redirect beats every other condition
  always_comb
    next_state = BranchTaken ? FLUSH :
                 state == FETCH ? ((IAck && Stall) ? HOLD : FETCH) :
                 state == HOLD  ? (Stall ? HOLD : FETCH) :
                 state == FLUSH ? (cnt_zero ? FETCH : FLUSH) : FETCH;
  // fetch request is decoded from state and suppressed while in reset
  always_comb IReq = state == FETCH && !Reset;
  // registered PC, captured instruction and flush flag
  always_ff @(posedge Clk)
    if (Reset) begin
      PCResult   <= RESET_PC;
      InstrOut   <= '0;
      InstrValid <= 1'b0;
      Flush      <= 1'b0;
    end else if (BranchTaken) begin
      PCResult   <= BranchTarget & ~32'd3;
      InstrValid <= 1'b0;
      Flush      <= 1'b1;
    end else if (state == FETCH) begin
      if (IAck) begin
        InstrOut   <= InstrIn;
        InstrValid <= 1'b1;
        if (!Stall) PCResult <= PCAddResult;
      end else if (!Stall) InstrValid <= 1'b0;
    end else if (state == HOLD) begin
      if (!Stall) begin
        PCResult   <= PCAddResult;
        InstrValid <= 1'b0;
      end
    end else if (state == FLUSH && cnt_zero) Flush <= 1'b0;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: scoreboard bench with directed fetch/stall/redirect/reset vectors
module tb_pc_fetch_ctrl;
  logic Clk = 1'b0, Reset = 1'b1, Stall = 1'b0, BranchTaken = 1'b0, IAck = 1'b0;
  logic [31:0] BranchTarget = '0, PCAddResult, InstrIn, PCResult, InstrOut;
  logic IReq, InstrValid, Flush;
  typedef struct packed {
    int          id;
    logic [31:0] pc;
    logic        iv;
    logic [31:0] ins;
    logic        fl;
    logic        rq;
  } exp_t;
  exp_t q[$];
  exp_t e, a;
  int errors = 0, checks = 0, n = 0;
  pc_fetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .PCAddResult(PCAddResult), .IAck(IAck),
    .InstrIn(InstrIn), .PCResult(PCResult), .IReq(IReq), .InstrOut(InstrOut),
    .InstrValid(InstrValid), .Flush(Flush)
  );
  always #5 Clk = ~Clk;
  function automatic logic [31:0] ins(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0000;
  endfunction
  assign PCAddResult = PCResult + 32'd4;
  assign InstrIn = ins(PCResult);
  always @(negedge Clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{e.id, PCResult, InstrValid, InstrOut, Flush, IReq};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL step%0d: got pc=%h iv=%b instr=%h flush=%b ireq=%b, want pc=%h iv=%b instr=%h flush=%b ireq=%b",
                 e.id, a.pc, a.iv, a.ins, a.fl, a.rq, e.pc, e.iv, e.ins, e.fl, e.rq);
      end
    end
  task automatic cyc(input logic r, s, ak, b, input logic [31:0] t,
                     input logic [31:0] pc, input logic iv, input logic [31:0] i, input logic fl, rq);
    Reset = r; Stall = s; IAck = ak; BranchTaken = b; BranchTarget = t;
    @(posedge Clk);
    n++;
    q.push_back('{n, pc, iv, i, fl, rq});
    @(negedge Clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    cyc(1, 0, 0, 0, 0,        0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 'h500,    0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0,        4, 1, ins(0), 0, 1);
    cyc(0, 0, 1, 0, 0,        8, 1, ins(4), 0, 1);
    cyc(0, 1, 1, 0, 0,        8, 1, ins(8), 0, 0);
    cyc(0, 1, 1, 0, 0,        8, 1, ins(8), 0, 0);
    cyc(0, 1, 1, 0, 0,        8, 1, ins(8), 0, 0);
    cyc(0, 0, 1, 0, 0,        12, 0, ins(8), 0, 1);
    cyc(0, 0, 0, 0, 0,        12, 0, ins(8), 0, 1);
    cyc(0, 0, 1, 0, 0,        16, 1, ins(12), 0, 1);
    cyc(0, 1, 0, 0, 0,        16, 1, ins(12), 0, 1);
    cyc(0, 0, 1, 1, 'h103,    'h100, 0, ins(12), 1, 0);
    cyc(0, 0, 1, 0, 0,        'h100, 0, ins(12), 1, 0);
    cyc(0, 0, 1, 0, 0,        'h100, 0, ins(12), 0, 1);
    cyc(0, 0, 1, 0, 0,        'h104, 1, ins('h100), 0, 1);
    cyc(0, 0, 0, 1, 'h180,    'h180, 0, ins('h100), 1, 0);
    cyc(0, 0, 0, 1, 'h200,    'h200, 0, ins('h100), 1, 0);
    cyc(0, 0, 0, 0, 0,        'h200, 0, ins('h100), 1, 0);
    cyc(0, 0, 0, 0, 0,        'h200, 0, ins('h100), 0, 1);
    cyc(0, 0, 0, 1, 'h300,    'h300, 0, ins('h100), 1, 0);
    cyc(1, 1, 1, 1, 'h400,    0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0,        0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 'hFFFF_FFFF, 'hFFFF_FFFC, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0,        'hFFFF_FFFC, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0,        'hFFFF_FFFC, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0,        0, 1, ins('hFFFF_FFFC), 0, 1);
    cyc(0, 1, 1, 0, 0,        0, 1, ins(0), 0, 0);
    cyc(0, 1, 1, 1, 'h40,     'h40, 0, ins(0), 1, 0);
    cyc(0, 0, 1, 0, 0,        'h40, 0, ins(0), 1, 0);
    cyc(0, 0, 1, 0, 0,        'h40, 0, ins(0), 0, 1);
    cyc(0, 1, 1, 0, 0,        'h40, 1, ins('h40), 0, 0);
    cyc(1, 1, 1, 0, 0,        0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0,        4, 1, ins(0), 0, 1);
    repeat (2) @(negedge Clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
